// File: rtl/uart_tx_scheduler_if.sv
// Requester-side bus of the UART transmit scheduler.
// master = requester fabric, slave = scheduler.
interface uart_tx_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   err;

  modport master (output req, output req_data, input grant, input ack, input err);
  modport slave  (input req, input req_data, output grant, output ack, output err);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NREQ requesters.
// The winner's byte and the frame config are latched at grant and held until the response.
// Optional feature macro: UART_TX_SCHED_TIMEOUT_EN adds a WAIT_DONE timeout that answers with err.
module uart_tx_scheduler #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned HOLD_CYCLES    = 10432,
  parameter int unsigned TIMEOUT_CYCLES = 400000
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_scheduler_if.slave  rq,
  input  logic [16:0]         cfg_baud,
  input  logic [3:0]          cfg_length,
  input  logic                cfg_parity_en,
  input  logic                cfg_parity_type,
  input  logic                cfg_stop2,
  output logic                busy,
  output logic                uart_tx_start,
  output logic [7:0]          uart_tx_data,
  output logic [16:0]         uart_baud,
  output logic [3:0]          uart_length,
  output logic                uart_parity_en,
  output logic                uart_parity_type,
  output logic                uart_stop2,
  input  logic                uart_tx_done
);

  localparam int unsigned PTR_W  = $clog2(NREQ);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  if (NREQ < 2 || NREQ > 8 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, GRANT, START, WAIT_DONE, RESP} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [NREQ-1:0]     err_q, err_d;
  logic                busy_d;
  logic                tx_start_d;
  logic                latch_c;
  logic [PTR_W-1:0]    win_c;
  logic [7:0]          byte_c;
  logic [2:0]          sync_q;
  logic                done_rise_c;
`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [31:0]         to_q, to_d;
`endif

  assign rq.grant = grant_q;
  assign rq.ack   = ack_q;
  assign rq.err   = err_q;

  function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // tx_done crosses from the tx_clk domain: two sync flops plus one edge-history flop
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], uart_tx_done};
  end

  assign done_rise_c = sync_q[1] & ~sync_q[2];

  // First pending request at or above rr_ptr, wrapping; rr_ptr is the default when idle
  always_comb begin
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    win_c = rr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && rq.req[PTR_W'(idx)]) begin
        found = 1'b1;
        win_c = PTR_W'(idx);
      end
    end
  end

  // Winner's byte out of the packed request data
  always_comb begin
    byte_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_c == PTR_W'(i)) byte_c = rq.req_data[8*i +: 8];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    hold_d  = '0;
    ack_d   = '0;
    err_d   = '0;
    latch_c = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    to_d    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (|rq.req) begin
          state_d = GRANT;
          owner_d = win_c;
          latch_c = 1'b1;
        end
      end
      GRANT: state_d = START;
      START: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) state_d = WAIT_DONE;
        else                                     hold_d  = hold_q + HOLD_W'(1);
      end
      WAIT_DONE: begin
        if (done_rise_c) begin
          state_d = RESP;
          ack_d   = onehot(owner_q);
        end
`ifdef UART_TX_SCHED_TIMEOUT_EN
        else if (to_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          err_d   = onehot(owner_q);
        end else begin
          to_d = to_q + 32'd1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
        rr_d    = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + PTR_W'(1);
      end
      default: state_d = IDLE;
    endcase
    grant_d    = (state_d != IDLE) ? onehot(owner_d) : '0;
    busy_d     = (state_d != IDLE);
    tx_start_d = (state_d == START);
  end

  // State, counters and registered outputs; config and byte captured only on the grant edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      rr_q             <= '0;
      owner_q          <= '0;
      hold_q           <= '0;
      grant_q          <= '0;
      ack_q            <= '0;
      err_q            <= '0;
      busy             <= 1'b0;
      uart_tx_start    <= 1'b0;
      uart_tx_data     <= '0;
      uart_baud        <= '0;
      uart_length      <= '0;
      uart_parity_en   <= 1'b0;
      uart_parity_type <= 1'b0;
      uart_stop2       <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      to_q             <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      owner_q       <= owner_d;
      hold_q        <= hold_d;
      grant_q       <= grant_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      busy          <= busy_d;
      uart_tx_start <= tx_start_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      to_q          <= to_d;
`endif
      if (latch_c) begin
        uart_tx_data     <= byte_c;
        uart_baud        <= cfg_baud;
        uart_length      <= cfg_length;
        uart_parity_en   <= cfg_parity_en;
        uart_parity_type <= cfg_parity_type;
        uart_stop2       <= cfg_stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: frame table plus hand sequences for
// fairness, reset mid-frame and (when UART_TX_SCHED_TIMEOUT_EN is defined) timeout.
module tb_uart_tx_scheduler;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned HOLD     = 16;
  localparam int unsigned TIMEOUT  = 1000;
  localparam int unsigned DONE_DLY = 10;

  logic        clk;
  logic        rst;
  logic [16:0] cfg_baud;
  logic [3:0]  cfg_length;
  logic        cfg_parity_en, cfg_parity_type, cfg_stop2;
  logic        busy, uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic [16:0] uart_baud;
  logic [3:0]  uart_length;
  logic        uart_parity_en, uart_parity_type, uart_stop2;
  logic        uart_tx_done;
  logic        uart_en;

  uart_tx_scheduler_if #(.NREQ(NREQ)) rq ();

  uart_tx_scheduler #(
    .NREQ(NREQ), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .rq(rq),
    .cfg_baud(cfg_baud), .cfg_length(cfg_length), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_type(cfg_parity_type), .cfg_stop2(cfg_stop2),
    .busy(busy), .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
    .uart_baud(uart_baud), .uart_length(uart_length), .uart_parity_en(uart_parity_en),
    .uart_parity_type(uart_parity_type), .uart_stop2(uart_stop2),
    .uart_tx_done(uart_tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int mon_bad = 0;

  typedef struct {
    logic [3:0] req;
    logic [7:0] base;
    logic [3:0] len;
    logic [3:0] exp_grant;
    logic [7:0] exp_data;
  } row_t;

  row_t rows [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Simple UART stand-in: tx_done pulses a fixed delay after tx_start falls
  initial begin
    uart_tx_done = 1'b0;
    forever begin
      @(negedge uart_tx_start);
      if (uart_en) begin
        repeat (DONE_DLY) @(posedge clk);
        #1 uart_tx_done = 1'b1;
        repeat (3) @(posedge clk);
        #1 uart_tx_done = 1'b0;
      end
    end
  end

  // grant/ack/err exclusivity; any response must go to the current owner
  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(rq.grant) > 1 || $countones(rq.ack) > 1 || $countones(rq.err) > 1 ||
          ((rq.ack | rq.err) != '0 && (rq.ack | rq.err) != rq.grant) ||
          (|rq.ack && |rq.err))
        mon_bad++;
    end
  end

  task automatic wait_grant(input logic [3:0] exp, input string name);
    int n;
    n = 0;
    while (rq.grant == '0 && n < 20) begin step(); n++; end
    chk(name, 32'(rq.grant), 32'(exp));
  endtask

  task automatic wait_ack(input logic [3:0] exp, input string name);
    int n;
    n = 0;
    while ((rq.ack | rq.err) == '0 && n < 300) begin step(); n++; end
    chk(name, 32'(rq.ack), 32'(exp));
    chk({name, "_err"}, 32'(rq.err), 32'd0);
  endtask

  // One table frame: applied in IDLE, inputs scrambled right after grant
  task automatic run_row(input int r);
    int n, h;
    logic [2:0]  exp_par;
    logic [16:0] exp_baud;
    exp_baud = 17'(9600 + r * 1111);
    exp_par  = {(r % 2) == 1, ((r / 2) % 2) == 1, ((r / 4) % 2) == 1};
    rq.req = rows[r].req;
    for (int i = 0; i < 4; i++) rq.req_data[8*i +: 8] = rows[r].base + 8'(i);
    cfg_length = rows[r].len;
    cfg_baud   = exp_baud;
    {cfg_parity_en, cfg_parity_type, cfg_stop2} = exp_par;
    n = 0;
    while (rq.grant == '0 && n < 20) begin step(); n++; end
    chk($sformatf("r%0d_grant", r), 32'(rq.grant), 32'(rows[r].exp_grant));
    chk($sformatf("r%0d_grant_lat", r), 32'(n), 32'd1);
    chk($sformatf("r%0d_data", r), 32'(uart_tx_data), 32'(rows[r].exp_data));
    chk($sformatf("r%0d_cfg", r), {8'd0, uart_baud, uart_length, uart_parity_en, uart_parity_type, uart_stop2},
        {8'd0, exp_baud, rows[r].len, exp_par});
    chk($sformatf("r%0d_busy", r), 32'(busy), 32'd1);
    rq.req          = '0;
    rq.req_data     = ~rq.req_data;
    cfg_length      = ~cfg_length;
    cfg_baud        = ~cfg_baud;
    cfg_parity_en   = ~cfg_parity_en;
    cfg_parity_type = ~cfg_parity_type;
    cfg_stop2       = ~cfg_stop2;
    n = 0;
    while (!uart_tx_start && n < 10) begin step(); n++; end
    chk($sformatf("r%0d_start_lat", r), 32'(n), 32'd1);
    h = 0;
    while (uart_tx_start && h < int'(HOLD) + 10) begin step(); h++; end
    chk($sformatf("r%0d_hold", r), 32'(h), 32'(HOLD));
    wait_ack(rows[r].exp_grant, $sformatf("r%0d_ack", r));
    chk($sformatf("r%0d_data_held", r), 32'(uart_tx_data), 32'(rows[r].exp_data));
    chk($sformatf("r%0d_len_held", r), 32'(uart_length), 32'(rows[r].len));
    step();
    chk($sformatf("r%0d_idle", r), {30'd0, busy, |rq.ack}, 32'd0);
    chk($sformatf("r%0d_grant_drop", r), 32'(rq.grant), 32'd0);
  endtask

  initial begin
    int n, bad;
    rows[0]  = '{4'b0001, 8'h5A, 4'd8, 4'b0001, 8'h5A};
    rows[1]  = '{4'b1111, 8'h10, 4'd7, 4'b0010, 8'h11};
    rows[2]  = '{4'b1111, 8'h20, 4'd6, 4'b0100, 8'h22};
    rows[3]  = '{4'b1111, 8'h30, 4'd5, 4'b1000, 8'h33};
    rows[4]  = '{4'b1111, 8'h40, 4'd8, 4'b0001, 8'h40};
    rows[5]  = '{4'b1111, 8'h50, 4'd8, 4'b0010, 8'h51};
    rows[6]  = '{4'b0101, 8'h60, 4'd8, 4'b0100, 8'h62};
    rows[7]  = '{4'b0101, 8'h70, 4'd5, 4'b0001, 8'h70};
    rows[8]  = '{4'b1000, 8'h80, 4'd8, 4'b1000, 8'h83};
    rows[9]  = '{4'b0110, 8'h90, 4'd7, 4'b0010, 8'h91};
    rows[10] = '{4'b1111, 8'hF0, 4'd5, 4'b0100, 8'hF2};

    uart_en         = 1'b0;
    rst             = 1'b1;
    rq.req          = '0;
    rq.req_data     = '0;
    cfg_baud        = '0;
    cfg_length      = '0;
    cfg_parity_en   = 1'b0;
    cfg_parity_type = 1'b0;
    cfg_stop2       = 1'b0;
    repeat (3) step();
    chk("rst_ctrl", {27'd0, busy, uart_tx_start, |rq.grant, |rq.ack, |rq.err}, 32'd0);
    chk("rst_data", {11'd0, uart_tx_data, uart_length, uart_baud[8:0]}, 32'd0);
    rst = 1'b0;
    step();
    uart_en = 1'b1;

    for (int r = 0; r < 11; r++) run_row(r);

    // requester 2 holds req, requester 1 raises a one-shot mid-frame (rr_ptr is 3 here)
    rq.req = 4'b0100;
    wait_grant(4'b0100, "fair_g2");
    step();
    rq.req = 4'b0110;
    wait_ack(4'b0100, "fair_a2");
    step();
    wait_grant(4'b0010, "fair_g1");
    wait_ack(4'b0010, "fair_a1");
    rq.req = 4'b0100;
    step();
    wait_grant(4'b0100, "fair_g2b");
    wait_ack(4'b0100, "fair_a2b");
    rq.req = '0;
    step();

    // reset while waiting for tx_done
    uart_en = 1'b0;
    rq.req  = 4'b1000;
    wait_grant(4'b1000, "rst_g3");
    n = 0;
    while (!uart_tx_start && n < 10) begin step(); n++; end
    while (uart_tx_start && n < 100) begin step(); n++; end
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("midrst_ctrl", {29'd0, busy, |rq.grant, uart_tx_start}, 32'd0);
    chk("midrst_data", 32'(uart_tx_data), 32'd0);
    rst    = 1'b0;
    rq.req = '0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ((rq.ack | rq.err) != '0 || busy) bad++;
    end
    chk("midrst_quiet", 32'(bad), 32'd0);
    uart_en = 1'b1;

    // rr_ptr restarts at 0 after reset
    rq.req = 4'b1100;
    wait_grant(4'b0100, "post_rst_g");
    wait_ack(4'b0100, "post_rst_a");
    rq.req = '0;
    step();

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // tx_done never arrives; err after TIMEOUT cycles of WAIT_DONE, then requester 1 served
    uart_en = 1'b0;
    rq.req  = 4'b0011;
    wait_grant(4'b0001, "to_g0");
    n = 0;
    while (!uart_tx_start && n < 10) begin step(); n++; end
    while (uart_tx_start && n < 100) begin step(); n++; end
    n = 0;
    while ((rq.ack | rq.err) == '0 && n < int'(TIMEOUT) + 50) begin step(); n++; end
    chk("to_err", 32'(rq.err), 32'b0001);
    chk("to_ack", 32'(rq.ack), 32'd0);
    chk("to_cycles", 32'(n), 32'(TIMEOUT));
    rq.req  = 4'b0010;
    uart_en = 1'b1;
    step();
    wait_grant(4'b0010, "to_next_g");
    wait_ack(4'b0010, "to_next_a");
    rq.req = '0;
    step();
`endif

    chk("exclusive_monitor", 32'(mon_bad), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
